read_response_packer: RTL and testbench

Packs AXI4 read-data beats (rid/rdata/rresp/rlast, qualified by rd_rsp_en) into 128-bit response packets and writes them into the read FIFO toward the host. It sits downstream of the AXI master read channel, alongside the write-response path. It produces the header/data/trailer packets the host side expects (SOP byte 8'hAA, EOP byte 8'h53). An internal beat buffer absorbs read-FIFO back-pressure.

---
 rtl/read_response_packer_pkg.sv | 46 ++++
 rtl/rresp_beat_fifo.sv | 66 ++++++
 rtl/read_response_packer.sv | 185 ++++++++++++++++++
 tb/tb_read_response_packer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_response_packer_pkg.sv
// Shared definitions for the read-response packer: framing bytes, field
// positions of the header/trailer words, FSM state encoding and a helper
// that assembles a header or trailer word.
package read_response_packer_pkg;

    localparam logic [7:0] SopByte = 8'hAA;
    localparam logic [7:0] EopByte = 8'h53;

    localparam int unsigned WordW   = 128;
    localparam int unsigned LaneW   = 32;
    localparam int unsigned CntW    = 12;

    // Header/trailer field positions
    localparam int unsigned TagMsb  = 127;
    localparam int unsigned TagLsb  = 120;
    localparam int unsigned RidMsb  = 119;
    localparam int unsigned RidLsb  = 116;
    localparam int unsigned RespMsb = 115;
    localparam int unsigned RespLsb = 112;
    localparam int unsigned CntMsb  = 111;
    localparam int unsigned CntLsb  = 100;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StData = 2'd2,
        StTail = 2'd3
    } state_e;

    // Header uses cnt = 0, so one builder serves both framing words.
    function automatic logic [WordW-1:0] pack_ctrl_word(
        input logic [7:0]      tag,
        input logic [3:0]      rid,
        input logic [3:0]      resp,
        input logic [CntW-1:0] cnt
    );
        logic [WordW-1:0] w;
        w                 = '0;
        w[TagMsb:TagLsb]   = tag;
        w[RidMsb:RidLsb]   = rid;
        w[RespMsb:RespLsb] = resp;
        w[CntMsb:CntLsb]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/rresp_beat_fifo.sv
// Synchronous first-word-fall-through FIFO holding read-data beats.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (flushes contents)
//   push_i/wdata_i write a beat (ignored when full)
//   pop_i          drop the head beat (ignored when empty)
//   rdata_o        head beat, valid whenever empty_o is low
//   count_o        registered occupancy, full_o/empty_o decoded from it
module rresp_beat_fifo #(
    parameter int unsigned Width = 41,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/read_response_packer.sv
// Packs AXI read-data beats into 128-bit header/data/trailer packets for the
// host-side read FIFO. Beats are buffered so read-FIFO back-pressure never
// stalls the AXI side until the buffer fills.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rid/rdata/rresp/rlast         incoming beat, qualified by rd_rsp_en
//   rd_rsp_ready                  beat buffer has room
//   fifo_full                     read FIFO back-pressure
//   write_enable/fifo_wdata       registered read FIFO write port
//   pkt_busy                      packet in progress
//   ovf_err                       sticky: a beat arrived while not ready
module read_response_packer
    import read_response_packer_pkg::*;
#(
    parameter int unsigned data_wid  = 32,
    parameter int unsigned id_wid    = 4,
    parameter int unsigned buf_depth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [id_wid-1:0]   rid,
    input  logic [data_wid-1:0] rdata,
    input  logic [3:0]          rresp,
    input  logic                rlast,
    input  logic                rd_rsp_en,
    output logic                rd_rsp_ready,
    input  logic                fifo_full,
    output logic                write_enable,
    output logic [WordW-1:0]    fifo_wdata,
    output logic                pkt_busy,
    output logic                ovf_err
);

    localparam int unsigned BeatW  = id_wid + 4 + 1 + data_wid;
    localparam int unsigned CountW = $clog2(buf_depth) + 1;
    localparam logic [CountW-1:0] DepthCnt = CountW'(buf_depth);

    // Beat buffer
    logic [BeatW-1:0]    push_beat, head_beat;
    logic [CountW-1:0]   buf_count;
    logic                buf_full, buf_empty, beat_pop;
    logic [data_wid-1:0] head_data;
    logic                head_last;
    logic [3:0]          head_resp;
    logic [id_wid-1:0]   head_rid;

    assign push_beat = {rid, rresp, rlast, rdata};
    assign head_data = head_beat[data_wid-1:0];
    assign head_last = head_beat[data_wid];
    assign head_resp = head_beat[data_wid+4:data_wid+1];
    assign head_rid  = head_beat[BeatW-1 -: id_wid];

    rresp_beat_fifo #(
        .Width (BeatW),
        .Depth (buf_depth)
    ) u_beat_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rd_rsp_en),
        .wdata_i (push_beat),
        .pop_i   (beat_pop),
        .rdata_o (head_beat),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign rd_rsp_ready = (buf_count < DepthCnt);

    // Packer state
    state_e            state_q, state_d;
    logic [WordW-1:0]  lanes_q, lanes_d;
    logic [1:0]        lane_idx_q, lane_idx_d;
    logic [3:0]        hdr_rid_q, hdr_rid_d;
    logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [3:0]        worst_q, worst_d;
    logic              we_q, wr_d;
    logic [WordW-1:0]  wdata_q, wword_d;
    logic              ovf_q;
    logic [WordW-1:0]  data_word;

    always_comb begin
        state_d    = state_q;
        lanes_d    = lanes_q;
        lane_idx_d = lane_idx_q;
        hdr_rid_d  = hdr_rid_q;
        beat_cnt_d = beat_cnt_q;
        worst_d    = worst_q;
        wr_d       = 1'b0;
        wword_d    = '0;
        beat_pop   = 1'b0;

        // Lanes above lane_idx_q are always zero, so the current beat just
        // drops into its slot to form the outgoing word.
        data_word = lanes_q;
        data_word[lane_idx_q*LaneW +: LaneW] = head_data;

        unique case (state_q)
            StIdle: begin
                if (!buf_empty) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (!fifo_full) begin
                    wr_d       = 1'b1;
                    wword_d    = pack_ctrl_word(SopByte, 4'(head_rid), head_resp, '0);
                    hdr_rid_d  = 4'(head_rid);
                    beat_cnt_d = '0;
                    worst_d    = '0;
                    lanes_d    = '0;
                    lane_idx_d = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (!buf_empty && !fifo_full) begin
                    beat_pop = 1'b1;
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (head_resp > worst_q) begin
                        worst_d = head_resp;
                    end
                    if (head_last || lane_idx_q == 2'd3) begin
                        wr_d       = 1'b1;
                        wword_d    = data_word;
                        lanes_d    = '0;
                        lane_idx_d = '0;
                    end else begin
                        lanes_d[lane_idx_q*LaneW +: LaneW] = head_data;
                        lane_idx_d = lane_idx_q + 2'd1;
                    end
                    if (head_last) begin
                        state_d = StTail;
                    end
                end
            end
            StTail: begin
                if (!fifo_full) begin
                    wr_d       = 1'b1;
                    wword_d    = pack_ctrl_word(EopByte, hdr_rid_q, worst_q, beat_cnt_q);
                    beat_cnt_d = '0;
                    worst_d    = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lanes_q    <= '0;
            lane_idx_q <= '0;
            hdr_rid_q  <= '0;
            beat_cnt_q <= '0;
            worst_q    <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lanes_q    <= lanes_d;
            lane_idx_q <= lane_idx_d;
            hdr_rid_q  <= hdr_rid_d;
            beat_cnt_q <= beat_cnt_d;
            worst_q    <= worst_d;
            we_q       <= wr_d;
            if (wr_d) begin
                wdata_q <= wword_d;
            end
            if (rd_rsp_en && buf_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign write_enable = we_q;
    assign fifo_wdata   = wdata_q;
    assign pkt_busy     = (state_q != StIdle);
    assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_read_response_packer.sv
module tb_read_response_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [3:0]   rresp;
    logic         rlast;
    logic         rd_rsp_en;
    logic         rd_rsp_ready;
    logic         fifo_full;
    logic         write_enable;
    logic [127:0] fifo_wdata;
    logic         pkt_busy;
    logic         ovf_err;

    always #5 clk = ~clk;

    read_response_packer #(
        .data_wid  (32),
        .id_wid    (4),
        .buf_depth (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rd_rsp_en    (rd_rsp_en),
        .rd_rsp_ready (rd_rsp_ready),
        .fifo_full    (fifo_full),
        .write_enable (write_enable),
        .fifo_wdata   (fifo_wdata),
        .pkt_busy     (pkt_busy),
        .ovf_err      (ovf_err)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned push_cyc = 0;
    logic        rnd_done;

    always @(posedge clk) cyc <= cyc + 1;

    // Everything the DUT writes to the read FIFO, with the cycle it appeared
    logic [127:0] got_q[$];
    int unsigned  gotcyc_q[$];
    logic [127:0] exp_q[$];

    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            got_q.push_back(fifo_wdata);
            gotcyc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic chkint(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference model: beats of the current burst, turned into packet words
    logic [3:0]  m_rid[$];
    logic [3:0]  m_resp[$];
    logic [31:0] m_data[$];

    task automatic model_add(input logic [3:0] r, input logic [31:0] d, input logic [3:0] rs);
        m_rid.push_back(r);
        m_data.push_back(d);
        m_resp.push_back(rs);
    endtask

    task automatic model_flush();
        logic [127:0] w;
        logic [3:0]   worst;
        int           n;
        int           cnt;
        n     = m_data.size();
        worst = 4'h0;
        w            = '0;
        w[127:120]   = 8'hAA;
        w[119:116]   = m_rid[0];
        w[115:112]   = m_resp[0];
        exp_q.push_back(w);
        w = '0;
        for (int k = 0; k < n; k++) begin
            w[(k % 4) * 32 +: 32] = m_data[k];
            if (m_resp[k] > worst) worst = m_resp[k];
            if ((k % 4) == 3 || k == n - 1) begin
                exp_q.push_back(w);
                w = '0;
            end
        end
        cnt        = (n > 4095) ? 4095 : n;
        w          = '0;
        w[127:120] = 8'h53;
        w[119:116] = m_rid[0];
        w[115:112] = worst;
        w[111:100] = 12'(cnt);
        exp_q.push_back(w);
        m_rid.delete();
        m_resp.delete();
        m_data.delete();
    endtask

    // Present one beat once the buffer has room; it is accepted at the next edge
    task automatic push_beat(input logic [3:0] r, input logic [31:0] d, input logic [3:0] rs,
                             input logic l);
        int budget;
        budget = 1000;
        while (rd_rsp_ready !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL push_timeout: rd_rsp_ready got 0, expected 1 within 1000 cycles");
        end
        rid       = r;
        rdata     = d;
        rresp     = rs;
        rlast     = l;
        rd_rsp_en = 1'b1;
        push_cyc  = cyc;
        tick();
        rd_rsp_en = 1'b0;
        model_add(r, d, rs);
        if (l) model_flush();
    endtask

    task automatic wait_words(input int n);
        int budget;
        budget = 3000;
        while (got_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        repeat (3) tick();
    endtask

    task automatic wait_we(input string name);
        int budget;
        budget = 200;
        while (write_enable !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        chk1({name, "_we_seen"}, write_enable, 1'b1);
    endtask

    task automatic compare_all(input string name);
        int n;
        chkint({name, "_nwords"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk128($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        gotcyc_q.delete();
        exp_q.delete();
    endtask

    task automatic run_random();
        int         n;
        logic [3:0] r0;
        logic [3:0] r;
        rnd_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 30; b++) begin
                    n  = $urandom_range(1, 9);
                    r0 = 4'($urandom);
                    for (int k = 0; k < n; k++) begin
                        r = (k > 0 && $urandom_range(0, 3) == 0) ? 4'($urandom) : r0;
                        if ($urandom_range(0, 2) == 0) tick();
                        push_beat(r, $urandom, 4'($urandom), k == n - 1);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    fifo_full = ($urandom_range(0, 99) < 30);
                    tick();
                end
                fifo_full = 1'b0;
            end
        join
        wait_words(exp_q.size());
        compare_all("random");
        chk1("random_no_ovf", ovf_err, 1'b0);
    endtask

    typedef struct {
        logic [3:0]   rid;
        int           n;
        logic [31:0]  base;
        int           hot;
        logic [3:0]   hot_resp;
        int           exp_words;
        logic [11:0]  exp_cnt;
        logic [3:0]   exp_worst;
        logic [127:0] exp_w1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        string        name;
        logic [127:0] exp_hdr;
        logic [127:0] exp_tail;
        int           n0;
        int           we_seen;

        vecs[0] = '{4'h3, 1, 32'hDEADBEEF, 0, 4'h0, 3, 12'h001, 4'h0,
                    {96'h0, 32'hDEADBEEF}};
        vecs[1] = '{4'h1, 6, 32'h1, 3, 4'h2, 4, 12'h006, 4'h2,
                    {32'h4, 32'h3, 32'h2, 32'h1}};
        vecs[2] = '{4'h5, 4, 32'h100, 0, 4'h7, 3, 12'h004, 4'h7,
                    {32'h103, 32'h102, 32'h101, 32'h100}};
        vecs[3] = '{4'hF, 8, 32'hA0, 7, 4'h1, 4, 12'h008, 4'h1,
                    {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[4] = '{4'h2, 9, 32'h0, 8, 4'hF, 5, 12'h009, 4'hF,
                    {32'h3, 32'h2, 32'h1, 32'h0}};
        vecs[5] = '{4'h9, 5, 32'hFFFFFFF0, 2, 4'h3, 4, 12'h005, 4'h3,
                    {32'hFFFFFFF3, 32'hFFFFFFF2, 32'hFFFFFFF1, 32'hFFFFFFF0}};

        rst       = 1'b1;
        rid       = '0;
        rdata     = '0;
        rresp     = '0;
        rlast     = 1'b0;
        rd_rsp_en = 1'b0;
        fifo_full = 1'b0;
        rnd_done  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        chk1("reset_ready", rd_rsp_ready, 1'b1);
        chk1("reset_we", write_enable, 1'b0);
        chk128("reset_wdata", fifo_wdata, 128'h0);
        chk1("reset_busy", pkt_busy, 1'b0);
        chk1("reset_ovf", ovf_err, 1'b0);

        // Table of single bursts
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                push_beat(vecs[v].rid, vecs[v].base + k,
                          (k == vecs[v].hot) ? vecs[v].hot_resp : 4'h0, k == vecs[v].n - 1);
            end
            wait_words(exp_q.size());
            name = $sformatf("vec%0d", v);
            chkint({name, "_words"}, got_q.size(), vecs[v].exp_words);
            if (got_q.size() >= 3) begin
                exp_hdr  = {8'hAA, vecs[v].rid, (vecs[v].hot == 0) ? vecs[v].hot_resp : 4'h0,
                            112'h0};
                exp_tail = {8'h53, vecs[v].rid, vecs[v].exp_worst, vecs[v].exp_cnt, 100'h0};
                chk128({name, "_hdr"}, got_q[0], exp_hdr);
                chk128({name, "_data1"}, got_q[1], vecs[v].exp_w1);
                chk128({name, "_trailer"}, got_q[got_q.size() - 1], exp_tail);
            end
            if (vecs[v].n == 1 && gotcyc_q.size() >= 3) begin
                chkint({name, "_hdr_lat"}, int'(gotcyc_q[0] - push_cyc), 3);
                chkint({name, "_data_lat"}, int'(gotcyc_q[1] - push_cyc), 4);
                chkint({name, "_tail_lat"}, int'(gotcyc_q[2] - push_cyc), 5);
            end
            chk1({name, "_idle"}, pkt_busy, 1'b0);
            compare_all(name);
        end

        // Header held under back-pressure, then a 10-cycle stall in DATA
        fifo_full = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push_beat(4'h6, 32'h1000 + k, (k == 5) ? 4'h1 : 4'h0, k == 5);
        end
        repeat (3) tick();
        chkint("stall_hdr_held", got_q.size(), 0);
        chk1("stall_busy", pkt_busy, 1'b1);
        fifo_full = 1'b0;
        wait_we("stall");
        fifo_full = 1'b1;
        tick();
        n0      = got_q.size();
        we_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (write_enable === 1'b1) we_seen++;
        end
        chkint("stall_no_we", we_seen, 0);
        chkint("stall_no_words", got_q.size(), n0);
        fifo_full = 1'b0;
        wait_words(exp_q.size());
        compare_all("stall");

        // Two bursts queued back to back
        for (int k = 0; k < 3; k++) push_beat(4'h1, 32'h2100 + k, 4'h0, k == 2);
        for (int k = 0; k < 2; k++) push_beat(4'h2, 32'h2200 + k, 4'h1, k == 1);
        wait_words(exp_q.size());
        compare_all("b2b");

        run_random();

        // Fill the buffer with the output blocked, then overrun it
        fifo_full = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rid       = 4'h7;
            rdata     = 32'h5000 + k;
            rresp     = 4'(k % 3);
            rlast     = (k == 15);
            rd_rsp_en = 1'b1;
            if (k == 15) chk1("ovf_ready_at_15", rd_rsp_ready, 1'b1);
            if (k == 16) begin
                chk1("ovf_ready_low_at_16", rd_rsp_ready, 1'b0);
                chk1("ovf_not_yet_set", ovf_err, 1'b0);
            end
            if (k < 16) model_add(4'h7, 32'h5000 + k, 4'(k % 3));
            if (k == 15) model_flush();
            tick();
        end
        rd_rsp_en = 1'b0;
        rlast     = 1'b0;
        chk1("ovf_set", ovf_err, 1'b1);
        fifo_full = 1'b0;
        wait_words(exp_q.size());
        compare_all("ovf");
        chk1("ovf_sticky", ovf_err, 1'b1);

        // Reset in the middle of DATA abandons the packet
        fifo_full = 1'b1;
        for (int k = 0; k < 6; k++) push_beat(4'hC, 32'h7000 + k, 4'h0, k == 5);
        exp_q.delete();
        fifo_full = 1'b0;
        wait_we("rstmid");
        tick();
        tick();
        n0  = got_q.size();
        rst = 1'b1;
        tick();
        chk1("rstmid_ready", rd_rsp_ready, 1'b1);
        chk1("rstmid_we", write_enable, 1'b0);
        chk128("rstmid_wdata", fifo_wdata, 128'h0);
        chk1("rstmid_busy", pkt_busy, 1'b0);
        chk1("rstmid_ovf", ovf_err, 1'b0);
        rst = 1'b0;
        repeat (20) tick();
        chkint("rstmid_no_trailer", got_q.size(), n0);
        got_q.delete();
        gotcyc_q.delete();
        for (int k = 0; k < 3; k++) push_beat(4'hD, 32'h8000 + k, 4'(k), k == 2);
        wait_words(exp_q.size());
        compare_all("rstmid_fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
